// File: rtl/gcd_pkg.sv
// gcd_pkg -- shared definitions for the GCD arbiter slice.
//   state_t   : arbiter FSM encoding (IDLE=0, START=1, RUN=2, RESP=3)
//   DEF_WIDTH : default operand/result width
//   DEF_N_REQ : default number of requesters
//   idx_width : bit width needed to hold a requester index (minimum 1)
package gcd_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker -- combinational round-robin selector.
// Scans req starting at index rr, wrapping from N_REQ-1 back to 0, and
// reports the first requester found.
//   req   : request levels, one bit per requester
//   rr    : index the scan starts from
//   pick  : one-hot selected requester (zero when req is zero)
//   index : binary index of the selected requester (zero when req is zero)
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    index
);

  logic found;
  int   slot;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pick  = '0;
    index = '0;
    found = 1'b0;
    slot  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      slot = int'(rr) + k;
      if (slot >= N_REQ) slot = slot - N_REQ;
      if (!found && req[slot]) begin
        found       = 1'b1;
        pick[slot]  = 1'b1;
        index       = IW'(slot);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter -- shares one external GCD engine between N_REQ requesters.
// A round-robin pick in IDLE latches the winner's operands and grants it;
// START raises eng_go until the engine reports busy (eng_done low), RUN waits
// for eng_done high and captures eng_out, RESP pulses ack for one cycle.
// A zero operand bypasses the engine entirely: result = A | B.
//   clk, rst          : clock, asynchronous active-low reset
//   req, a_in, b_in   : per-requester request level and operand slices
//   grant, ack, err   : one-hot service, completion pulse, timeout pulse
//   result, busy      : GCD value (valid with ack), FSM not idle
//   eng_go/a/b        : engine start and latched operands
//   eng_out, eng_done : engine result and idle/finished status
// Optional feature: define GCD_ARB_TIMEOUT_EN to add an engine watchdog that
// forces RESP with result 0 and err after TIMEOUT cycles in START+RUN.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic [N_REQ-1:0]       err,
  output logic                   busy,
  output logic                   eng_go,
  output logic [WIDTH-1:0]       eng_a,
  output logic [WIDTH-1:0]       eng_b,
  input  logic [WIDTH-1:0]       eng_out,
  input  logic                   eng_done
);

  localparam int IW = idx_width(N_REQ);

  state_t           state, state_nx;
  logic [IW-1:0]    rr, gidx, pick_idx;
  logic [N_REQ-1:0] pick;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             zero_op;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req   (req),
    .rr    (rr),
    .pick  (pick),
    .index (pick_idx)
  );

  assign sel_a   = a_in[int'(pick_idx)*WIDTH +: WIDTH];
  assign sel_b   = b_in[int'(pick_idx)*WIDTH +: WIDTH];
  // gcd(x,0) = x and gcd(0,0) = 0, so a zero operand never needs the engine.
  assign zero_op = (eng_a == '0) || (eng_b == '0);

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          to_q;

  // cnt holds the number of START+RUN cycles already spent, so reaching
  // TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign timeout_hit = ((state == START) || (state == RUN)) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      if (state == IDLE)                       cnt <= '0;
      else if (state == START || state == RUN) cnt <= cnt + CW'(1);
      if (timeout_hit)          to_q <= 1'b1;
      else if (state == RESP)   to_q <= 1'b0;
    end
  end

  assign err = (state == RESP && to_q) ? grant : '0;
`else
  assign err = '0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req)          state_nx = START;
      START: begin
        if (zero_op)              state_nx = RESP;
        else if (!eng_done)       state_nx = RUN;
      end
      RUN:     if (eng_done)      state_nx = RESP;
      RESP:                       state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
`ifdef GCD_ARB_TIMEOUT_EN
    if (timeout_hit) state_nx = RESP;
`endif
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: operand and result registers are reset too, because the engine and
  // observers see them directly as outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr     <= '0;
      gidx   <= '0;
      grant  <= '0;
      eng_a  <= '0;
      eng_b  <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (|req) begin
          grant <= pick;
          gidx  <= pick_idx;
          eng_a <= sel_a;
          eng_b <= sel_b;
        end
        START: if (zero_op)  result <= eng_a | eng_b;
        RUN:   if (eng_done) result <= eng_out;
        RESP: begin
          grant <= '0;
          rr    <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
        end
        default: ;
      endcase
`ifdef GCD_ARB_TIMEOUT_EN
      if (timeout_hit) result <= '0;
`endif
    end
  end

  assign busy   = (state != IDLE);
  assign eng_go = (state == START) && !zero_op;
  assign ack    = (state == RESP) ? grant : '0;

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one gcd_machine engine.
REQ-002 Parameter WIDTH, default 8, operand/result width.
REQ-003 Parameter TIMEOUT, default 255, engine watchdog limit in cycles; used only under GCD_ARB_TIMEOUT_EN.
REQ-004 The module SHALL provide these ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request level.
- a_in  input  N_REQ*WIDTH  operand A; slice i belongs to requester i.
- b_in  input  N_REQ*WIDTH  operand B; slice i belongs to requester i.
- grant  output  N_REQ  one-hot; high while requester i is served.
- ack  output  N_REQ  one-cycle completion pulse for requester i.
- result  output  WIDTH  GCD value, valid in the ack cycle.
- err  output  N_REQ  one-cycle timeout pulse, coincident with ack.
- busy  output  1  high whenever state is not IDLE.
- eng_go  output  1  start request to the engine.
- eng_a  output  WIDTH  latched operand A to the engine.
- eng_b  output  WIDTH  latched operand B to the engine.
- eng_out  input  WIDTH  engine result.
- eng_done  input  1  engine status; high = idle/finished, low = computing.

Function
REQ-005 FSM states SHALL be IDLE, START, RUN and RESP, all registered.
REQ-006 IDLE with any req bit high: select requester by round-robin from pointer rr, latch its a/b into eng_a/eng_b, assert its grant, go to START next cycle.
REQ-007 Round-robin: search starts at rr and wraps from N_REQ-1 to 0; in RESP, rr SHALL become (granted index + 1) mod N_REQ.
REQ-008 Zero bypass: if the latched A or B is 0, skip START/RUN, go straight to RESP with result = A|B (gcd(x,0)=x, gcd(0,0)=0), and never assert eng_go.
REQ-009 START: eng_go=1; remain in START until eng_done==0, then go to RUN.
REQ-010 RUN: eng_go=0; remain in RUN until eng_done==1, then latch eng_out into result and go to RESP.
REQ-011 RESP: pulse ack[i] for exactly one cycle, deassert grant in the next cycle, return to IDLE.
REQ-012 A new grant SHALL NOT be issued in the RESP cycle; minimum gap between consecutive grants is one IDLE cycle.
REQ-013 Requesters SHALL hold req and operands stable until ack; operands are sampled only at grant.
REQ-014 Dropping req mid-service SHALL NOT abort; ack is still pulsed.
REQ-015 req bits that rise while busy SHALL wait; no request is lost while its req stays high.
REQ-016 grant SHALL always be one-hot or zero; ack and err only for the granted index.

Reset
REQ-017 rst low SHALL asynchronously force: state=IDLE, rr=0, grant=0, ack=0, err=0, busy=0, eng_go=0, eng_a=0, eng_b=0, result=0.
REQ-018 Reset during START or RUN SHALL abandon the operation with no ack; the engine is re-synchronised by its own reset.

Configuration
REQ-019 Macro GCD_ARB_TIMEOUT_EN defined: a counter clears on entering START and counts cycles in START+RUN.
- At TIMEOUT cycles: go to RESP with result=0, ack[i]=1, err[i]=1, eng_go=0.
REQ-020 GCD_ARB_TIMEOUT_EN undefined: no counter, err tied to 0, and START/RUN wait indefinitely.

Structure
REQ-021 Shared package gcd_pkg SHALL hold the state encoding (IDLE=0, START=1, RUN=2, RESP=3) and default WIDTH/N_REQ constants.
REQ-022 Round-robin selection SHALL be the sub-module rr_picker: inputs req and rr, outputs one-hot pick and index; purely combinational.

Verification
REQ-023 Single request: req[0]=1, a=15, b=24 with a real gcd_machine -> grant[0], eng_go until eng_done falls, ack[0] with result=3.
REQ-024 Contention: req=4'b1111, all operands 12/18 -> grants in order 0,1,2,3; four acks, each result=6; never two grants high.
REQ-025 Fairness wrap: rr=3 after serving 2, req=4'b1001 -> requester 3 served first, then 0.
REQ-026 Zero bypass: a=0, b=9 -> ack with result=9 two cycles after grant, eng_go never high; a=b=0 -> result=0.
REQ-027 Reset mid-RUN: rst low for 1 cycle -> all outputs 0 immediately, no ack; a later request completes normally.
REQ-028 With GCD_ARB_TIMEOUT_EN and a stub holding eng_done=0: after 255 cycles -> ack and err pulse together, result=0, then IDLE.
